change_dispenser: RTL and testbench

Coin-payout engine on the receiving end of the vending machine's change output. It accepts a change amount (in coin units) over a valid/ready handshake and pays it out greedily as timed coin-eject pulses from two coin tubes: 2-unit and 1-unit. It tracks tube inventories and reports any amount it could not pay.

---
 rtl/change_dispenser.sv | 182 ++++++++++++++++++
 tb/tb_change_dispenser.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin-payout engine for a vending machine's change output.
// Accepts an amount over valid/ready, ejects 2-unit then 1-unit coins as timed pulses,
// tracks both tube inventories and reports any remainder it could not pay.
module change_dispenser #(
    parameter int unsigned PULSE_W  = 2,
    parameter int unsigned GAP_W    = 2,
    parameter int unsigned INV_W    = 4,
    parameter int unsigned INV_INIT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic [2:0]       req_amt,
    output logic             req_ready,
    input  logic             refill,
    output logic             disp2,
    output logic             disp1,
    output logic             busy,
    output logic             done,
    output logic             short,
    output logic [2:0]       short_amt,
    output logic [INV_W-1:0] inv2,
    output logic [INV_W-1:0] inv1
);

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StPulse,
        StGap,
        StDone
    } state_t;

    localparam int unsigned       CNT_W      = 8;
    localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(GAP_W - 1);
    localparam logic [INV_W-1:0]  INV_RST    = INV_W'(INV_INIT);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_sel2;     // 1: current coin is from the 2-unit tube
    logic [2:0]         r_rem;
    logic [INV_W-1:0]   r_inv2;
    logic [INV_W-1:0]   r_inv1;
    logic               r_short;
    logic [2:0]         r_short_amt;

    logic               w_accept;
    logic               w_refill;
    logic               w_pick2;
    logic               w_pick1;
    logic               w_pay;
    logic               w_finish;

    // State and phase-counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state decode and datapath control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_refill    = 1'b0;
        w_pick2     = 1'b0;
        w_pick1     = 1'b0;
        w_pay       = 1'b0;
        w_finish    = 1'b0;
        unique case (r_state)
            StIdle: begin
                // A request beats a simultaneous refill; the refill is dropped
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = StSelect;
                end else if (refill) begin
                    w_refill = 1'b1;
                end
            end
            StSelect: begin
                w_cnt_nxt = '0;
                if (r_rem >= 3'd2 && r_inv2 != '0) begin
                    w_pick2     = 1'b1;
                    w_state_nxt = StPulse;
                end else if (r_rem != 3'd0 && r_inv1 != '0) begin
                    w_pick1     = 1'b1;
                    w_state_nxt = StPulse;
                end else begin
                    w_finish    = 1'b1;
                    w_state_nxt = StDone;
                end
            end
            StPulse: begin
                if (r_cnt == PULSE_LAST) begin
                    w_pay       = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = StGap;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StGap: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = StSelect;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // Remainder, coin selection, inventories and shortfall report
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sel2      <= 1'b0;
            r_rem       <= '0;
            r_inv2      <= INV_RST;
            r_inv1      <= INV_RST;
            r_short     <= 1'b0;
            r_short_amt <= '0;
        end else begin
            if (w_accept) begin
                r_rem       <= req_amt;
                r_short     <= 1'b0;
                r_short_amt <= '0;
            end
            if (w_refill) begin
                r_inv2 <= INV_RST;
                r_inv1 <= INV_RST;
            end
            if (w_pick2) begin
                r_sel2 <= 1'b1;
            end else if (w_pick1) begin
                r_sel2 <= 1'b0;
            end
            // Selection guarantees value <= rem and count > 0, so no underflow here
            if (w_pay) begin
                if (r_sel2) begin
                    r_rem  <= r_rem - 3'd2;
                    r_inv2 <= r_inv2 - 1'b1;
                end else begin
                    r_rem  <= r_rem - 3'd1;
                    r_inv1 <= r_inv1 - 1'b1;
                end
            end
            // Loaded on entry to DONE so the report is visible with the done pulse
            if (w_finish) begin
                r_short     <= (r_rem != 3'd0);
                r_short_amt <= r_rem;
            end
        end
    end

    // Outputs decoded from state so reset drops the eject lines without a clock
    always_comb begin
        req_ready = (r_state == StIdle);
        busy      = (r_state != StIdle);
        done      = (r_state == StDone);
        disp2     = (r_state == StPulse) && r_sel2;
        disp1     = (r_state == StPulse) && !r_sel2;
        short     = r_short;
        short_amt = r_short_amt;
        inv2      = r_inv2;
        inv1      = r_inv1;
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a default instance (INV_INIT=8) and a
// small-inventory instance (INV_INIT=1) share clock and reset.
module tb_change_dispenser;

    localparam int PW = 2;
    localparam int GW = 2;
    localparam int BUDGET = 200;

    typedef struct {
        int n2;
        int n1;
        int shrt;
        int samt;
        int inv2;
        int inv1;
        int done_cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       rv [2];
    logic [2:0] ra [2];
    logic       rf [2];
    logic       rdy [2];
    logic       d2 [2];
    logic       d1 [2];
    logic       bsy [2];
    logic       dn [2];
    logic       sh [2];
    logic [2:0] sa [2];
    logic [3:0] i2 [2];
    logic [3:0] i1 [2];

    int   n_vec;
    int   n_err;
    int   m_inv2 [2];
    int   m_inv1 [2];
    int   init_inv [2];
    exp_t sb [$];

    change_dispenser #(
        .PULSE_W (PW),
        .GAP_W   (GW),
        .INV_W   (4),
        .INV_INIT(8)
    ) u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .req_valid(rv[0]),
        .req_amt  (ra[0]),
        .req_ready(rdy[0]),
        .refill   (rf[0]),
        .disp2    (d2[0]),
        .disp1    (d1[0]),
        .busy     (bsy[0]),
        .done     (dn[0]),
        .short    (sh[0]),
        .short_amt(sa[0]),
        .inv2     (i2[0]),
        .inv1     (i1[0])
    );

    change_dispenser #(
        .PULSE_W (PW),
        .GAP_W   (GW),
        .INV_W   (4),
        .INV_INIT(1)
    ) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .req_valid(rv[1]),
        .req_amt  (ra[1]),
        .req_ready(rdy[1]),
        .refill   (rf[1]),
        .disp2    (d2[1]),
        .disp1    (d1[1]),
        .busy     (bsy[1]),
        .done     (dn[1]),
        .short    (sh[1]),
        .short_amt(sa[1]),
        .inv2     (i2[1]),
        .inv1     (i1[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_inv2[d] = init_inv[d];
            m_inv1[d] = init_inv[d];
        end
    endtask

    // Drive one request; expected outcome comes from a greedy model of the tubes
    task automatic do_req(input int d, input int amt, input bit with_refill);
        exp_t e;
        int   rem;
        int   c;
        int   got;
        int   c2;
        int   c1;
        int   first;
        int   last2;
        int   first1;
        int   both;
        int   rdy_busy;
        int   o_sh;
        int   o_sa;
        int   o_i2;
        int   o_i1;
        rem  = amt;
        e.n2 = 0;
        e.n1 = 0;
        for (int k = 0; k < 8; k++) begin
            if (rem >= 2 && m_inv2[d] > 0) begin
                rem -= 2; m_inv2[d]--; e.n2++;
            end else if (rem >= 1 && m_inv1[d] > 0) begin
                rem -= 1; m_inv1[d]--; e.n1++;
            end
        end
        e.shrt     = (rem != 0) ? 1 : 0;
        e.samt     = rem;
        e.inv2     = m_inv2[d];
        e.inv1     = m_inv1[d];
        e.done_cyc = (e.n2 + e.n1) * (1 + PW + GW) + 2;
        sb.push_back(e);

        @(negedge clk);
        rv[d] = 1'b1;
        ra[d] = 3'(amt);
        rf[d] = with_refill;
        @(negedge clk);
        rv[d] = 1'b0;
        rf[d] = 1'b0;
        c = 1; got = 0; c2 = 0; c1 = 0; first = -1; last2 = -1; first1 = -1;
        both = 0; rdy_busy = 0; o_sh = 0; o_sa = 0; o_i2 = 0; o_i1 = 0;
        while (c < BUDGET && got == 0) begin
            if (d2[d] && d1[d]) both++;
            if (rdy[d]) rdy_busy++;
            if (d2[d]) begin
                c2++; last2 = c;
                if (first < 0) first = c;
            end
            if (d1[d]) begin
                c1++;
                if (first1 < 0) first1 = c;
                if (first < 0) first = c;
            end
            if (dn[d]) begin
                got = 1;
                o_sh = int'(sh[d]); o_sa = int'(sa[d]);
                o_i2 = int'(i2[d]); o_i1 = int'(i1[d]);
            end else begin
                @(negedge clk);
                c++;
            end
        end
        e = sb.pop_front();
        check_eq("done_seen", got, 1);
        check_eq("done_cycle", c, e.done_cyc);
        check_eq("disp2_cycles", c2, e.n2 * PW);
        check_eq("disp1_cycles", c1, e.n1 * PW);
        check_eq("first_pulse", first, (e.n2 + e.n1 > 0) ? 2 : -1);
        if (e.n2 > 0 && e.n1 > 0) check_eq("order_2_then_1", int'(first1 > last2), 1);
        check_eq("disp_overlap", both, 0);
        check_eq("ready_while_busy", rdy_busy, 0);
        check_eq("short", o_sh, e.shrt);
        check_eq("short_amt", o_sa, e.samt);
        check_eq("inv2", o_i2, e.inv2);
        check_eq("inv1", o_i1, e.inv1);
        @(negedge clk);
        check_eq("ready_after_done", int'(rdy[d]), 1);
        check_eq("done_one_cycle", int'(dn[d]), 0);
        check_eq("short_hold", int'(sh[d]), e.shrt);
        check_eq("short_amt_hold", int'(sa[d]), e.samt);
    endtask

    task automatic do_refill(input int d);
        @(negedge clk);
        rf[d] = 1'b1;
        @(negedge clk);
        rf[d] = 1'b0;
        m_inv2[d] = init_inv[d];
        m_inv1[d] = init_inv[d];
        check_eq("refill_inv2", int'(i2[d]), m_inv2[d]);
        check_eq("refill_inv1", int'(i1[d]), m_inv1[d]);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        init_inv[0] = 8;
        init_inv[1] = 1;
        for (int d = 0; d < 2; d++) begin
            rv[d] = 1'b0; ra[d] = 3'd0; rf[d] = 1'b0;
        end
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq("rst_ready", int'(rdy[d]), 1);
            check_eq("rst_busy", int'(bsy[d]), 0);
            check_eq("rst_done", int'(dn[d]), 0);
            check_eq("rst_disp", int'({d2[d], d1[d]}), 0);
            check_eq("rst_short", int'({sh[d], sa[d]}), 0);
            check_eq("rst_inv2", int'(i2[d]), init_inv[d]);
            check_eq("rst_inv1", int'(i1[d]), init_inv[d]);
        end
        rst = 1'b1;

        // Default instance: 3 units, then a zero-amount request
        do_req(0, 3, 1'b0);
        do_req(0, 0, 1'b0);

        // Small-inventory instance: shortfalls, refill, greedy fallback
        do_req(1, 5, 1'b0);
        do_req(1, 1, 1'b0);
        do_refill(1);
        do_req(1, 7, 1'b0);
        do_refill(1);
        do_req(1, 6, 1'b0);
        // Request and refill together: request wins, tubes stay empty
        do_req(1, 1, 1'b1);

        // Inputs ignored while busy, then asynchronous reset mid-pulse
        @(negedge clk);
        rv[0] = 1'b1; ra[0] = 3'd3;
        @(negedge clk);                 // cycle 1
        rv[0] = 1'b0;
        @(negedge clk);                 // cycle 2: first 2-unit pulse
        check_eq("busy_disp2", int'(d2[0]), 1);
        rv[0] = 1'b1; ra[0] = 3'd7; rf[0] = 1'b1;
        check_eq("busy_ready", int'(rdy[0]), 0);
        @(negedge clk);                 // cycle 3
        rv[0] = 1'b0; rf[0] = 1'b0;
        check_eq("busy_ready2", int'(rdy[0]), 0);
        check_eq("busy_inv1_norefill", int'(i1[0]), m_inv1[0]);
        repeat (4) @(negedge clk);      // cycle 7: 1-unit pulse
        check_eq("mid_inv2", int'(i2[0]), m_inv2[0] - 1);
        check_eq("mid_inv1", int'(i1[0]), m_inv1[0]);
        check_eq("mid_disp1", int'(d1[0]), 1);
        #1 rst = 1'b0;
        #1;
        model_reset();
        check_eq("arst_disp", int'({d2[0], d1[0]}), 0);
        check_eq("arst_busy", int'(bsy[0]), 0);
        check_eq("arst_ready", int'(rdy[0]), 1);
        check_eq("arst_inv2", int'(i2[0]), m_inv2[0]);
        check_eq("arst_inv1", int'(i1[0]), m_inv1[0]);
        @(negedge clk);
        rst = 1'b1;
        do_req(0, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
